// File: rtl/alu_packet_serializer.sv
// Frames one ALU request into 11-bit serial packets: A bytes, B bytes, cmd with CRC-4.
// Optional ALU_SER_CRC_INJECT_EN adds req_crc_flip to corrupt the sent CRC.
module alu_packet_serializer #(
    parameter int DATA_BYTES = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 req_valid,
    output logic                                 req_ready,
    input  logic [8*DATA_BYTES-1:0]              req_a,
    input  logic [8*DATA_BYTES-1:0]              req_b,
    input  logic [2:0]                           req_op,
    input  logic [$clog2(DATA_BYTES+1)-1:0]      req_drop_a,
    input  logic [$clog2(DATA_BYTES+1)-1:0]      req_drop_b,
`ifdef ALU_SER_CRC_INJECT_EN
    input  logic [3:0]                           req_crc_flip,
`endif
    output logic                                 sin,
    output logic                                 busy,
    output logic                                 done
);
    localparam int DW = $clog2(DATA_BYTES + 1);
    localparam int W  = 8 * DATA_BYTES;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DATA_A = 2'd1;
    localparam logic [1:0] DATA_B = 2'd2;
    localparam logic [1:0] CMD    = 2'd3;

    logic [1:0]    state;
    logic [3:0]    bit_cnt;
    logic [DW-1:0] byte_cnt;
    logic [W-1:0]  a_sh;
    logic [W-1:0]  b_sh;
    logic [2:0]    op_q;
    logic [DW-1:0] drop_a_q;
    logic [DW-1:0] drop_b_q;
    logic [3:0]    crc_q;
    logic [3:0]    crc_tx;
    logic          done_q;

    logic          last_byte;
    logic          is_cmd;
    logic          muted;
    logic [7:0]    payload;
    logic [7:0]    cur_byte;
    logic [DW-1:0] cur_drop;

    function automatic logic [3:0] crc_calc(input logic [2*W+3:0] s);
        logic [3:0] c;
        logic       fb;
        c = 4'h0;
        for (int i = 2*W+3; i >= 0; i--) begin
            fb = s[i] ^ c[3];
            c  = {c[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
        end
        return c;
    endfunction

    function automatic logic [DW-1:0] sat(input logic [DW-1:0] d);
        return (d > DW'(DATA_BYTES)) ? DW'(DATA_BYTES) : d;
    endfunction

`ifdef ALU_SER_CRC_INJECT_EN
    logic [3:0] flip_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flip_q <= 4'h0;
        end else if (state == IDLE && req_valid) begin
            flip_q <= req_crc_flip;
        end
    end

    assign crc_tx = crc_q ^ flip_q;
`else
    assign crc_tx = crc_q;
`endif

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign done      = done_q;
    assign last_byte = (byte_cnt == DW'(DATA_BYTES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            bit_cnt  <= 4'd0;
            byte_cnt <= '0;
            a_sh     <= '0;
            b_sh     <= '0;
            op_q     <= 3'd0;
            drop_a_q <= '0;
            drop_b_q <= '0;
            crc_q    <= 4'h0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state == IDLE) begin
                if (req_valid) begin
                    a_sh     <= req_a;
                    b_sh     <= req_b;
                    op_q     <= req_op;
                    drop_a_q <= sat(req_drop_a);
                    drop_b_q <= sat(req_drop_b);
                    crc_q    <= crc_calc({req_a, req_b, 1'b1, req_op});
                    bit_cnt  <= 4'd0;
                    byte_cnt <= '0;
                    state    <= DATA_A;
                end
            end else if (bit_cnt != 4'd10) begin
                bit_cnt <= bit_cnt + 4'd1;
            end else begin
                bit_cnt <= 4'd0;
                // Operands shift out a byte per packet, dropped or not
                if (state == DATA_A) a_sh <= a_sh << 8;
                if (state == DATA_B) b_sh <= b_sh << 8;
                if (state == CMD) begin
                    state  <= IDLE;
                    done_q <= 1'b1;
                end else if (last_byte) begin
                    byte_cnt <= '0;
                    state    <= (state == DATA_A) ? DATA_B : CMD;
                end else begin
                    byte_cnt <= byte_cnt + 1'b1;
                end
            end
        end
    end

    always_comb begin
        cur_byte = (state == DATA_A) ? a_sh[W-1 -: 8] : b_sh[W-1 -: 8];
        cur_drop = (state == DATA_A) ? drop_a_q : drop_b_q;
        is_cmd   = (state == CMD);
        payload  = is_cmd ? {1'b0, op_q, crc_tx} : cur_byte;
        muted    = !is_cmd && (byte_cnt < cur_drop);
        sin      = 1'b1;
        if (state != IDLE && !muted) begin
            unique case (1'b1)
                bit_cnt == 4'd0:  sin = 1'b0;
                bit_cnt == 4'd1:  sin = is_cmd;
                bit_cnt == 4'd10: sin = 1'b1;
                default:          sin = payload[3'(4'd9 - bit_cnt)];
            endcase
        end
    end
endmodule
